bounce_box_gen: RTL and testbench

BOUNCE_BOX_GEN -- requirements
Module: bounce_box_gen

---
 rtl/vga_pkg.sv | 25 ++
 rtl/box_axis.sv | 69 ++++++
 rtl/bounce_box_gen.sv | 115 +++++++++++
 tb/tb_bounce_box_gen.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA definitions: active-area size, colour type and constants, and
// the foreground palette used by the bouncing-box generator.
package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;

    // One 12-bit pixel, red in the top nibble.
    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

    localparam rgb_t RGB_BLACK      = 12'h000;
    localparam rgb_t RGB_BACKGROUND = 12'h004;

    // Foreground palette, entry 0 in the lowest slot: red, green, blue, yellow.
    localparam rgb_t [3:0] PALETTE = {12'hFF0, 12'h00F, 12'h0F0, 12'hF00};

    function automatic rgb_t palette_colour(input logic [1:0] idx);
        return PALETTE[idx];
    endfunction

endpackage

// File: rtl/box_axis.sv
// One axis of the bouncing box: position in 0..LIMIT, a direction bit
// (1 = increasing) and a bounce flag raised in the cycle the axis reverses.
module box_axis #(
    parameter int LIMIT = 608,
    parameter int STEP  = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       STEP_EN,
    output logic [9:0] POS,
    output logic       DIR,
    output logic       BOUNCE
);

    // Arithmetic is one bit wider than the position so POS+STEP never wraps.
    localparam logic [10:0] LIMIT_W = 11'(LIMIT);
    localparam logic [10:0] STEP_W  = 11'(STEP);

    logic [9:0]  pos_q, pos_d;
    logic        dir_q, dir_d;
    logic [10:0] pos_ext;
    logic [10:0] fwd;

    assign pos_ext = {1'b0, pos_q};
    assign fwd     = pos_ext + STEP_W;

    // Next position/direction for one frame step, clamping at either wall.
    always_comb begin
        // NOTE: every output of this block is defaulted first so no path leaves it unassigned (no latch).
        pos_d  = pos_q;
        dir_d  = dir_q;
        BOUNCE = 1'b0;
        if (STEP_EN) begin
            if (dir_q) begin
                if (fwd < LIMIT_W) begin
                    pos_d = fwd[9:0];
                end else begin
                    pos_d  = LIMIT_W[9:0];
                    dir_d  = 1'b0;
                    BOUNCE = 1'b1;
                end
            end else begin
                if (pos_ext > STEP_W) begin
                    pos_d = 10'(pos_ext - STEP_W);
                end else begin
                    pos_d  = '0;
                    dir_d  = 1'b1;
                    BOUNCE = 1'b1;
                end
            end
        end
    end

    // Position and direction registers; reset parks the box at 0 heading up.
    always_ff @(posedge CLK) begin
        // NOTE: state is written with <= so every register samples pre-edge values.
        if (RST) begin
            pos_q <= '0;
            dir_q <= 1'b1;
        end else begin
            pos_q <= pos_d;
            dir_q <= dir_d;
        end
    end

    assign POS = pos_q;
    assign DIR = dir_q;

endmodule

// File: rtl/bounce_box_gen.sv
// Bouncing-box pattern generator: moves a square once per frame, counts
// wall bounces, cycles the box colour on each bounce, and registers one
// pixel colour per pixel-enable from the incoming raster coordinates.
module bounce_box_gen
    import vga_pkg::*;
#(
    parameter int BOX_SIZE = 32,
    parameter int STEP     = 2,
    parameter int WIDTH    = H_ACTIVE,
    parameter int HEIGHT   = V_ACTIVE
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       PIX_EN,
    input  logic [9:0] H_CNT,
    input  logic [9:0] V_CNT,
    input  logic       ACTIVE,
    input  logic       FRAME_START,
    output logic [3:0] VGA_R,
    output logic [3:0] VGA_G,
    output logic [3:0] VGA_B,
    output logic [7:0] BOUNCE_CNT
);

    localparam logic [10:0] BOX_W = 11'(BOX_SIZE);

    logic       frame_step;
    logic [9:0] x_pos, y_pos;
    logic       x_dir, y_dir;
    logic       x_bounce, y_bounce;
    logic       bounce_evt;
    logic       unused_dir;

    logic [7:0] cnt_q, cnt_d;
    logic [1:0] pal_q, pal_d;
    rgb_t       rgb_q, rgb_d;

    logic [10:0] h_ext, v_ext, x_ext, y_ext;
    logic        in_box;

    // A frame step only counts when FRAME_START coincides with a pixel enable.
    assign frame_step = PIX_EN & FRAME_START;

    box_axis #(
        .LIMIT (WIDTH - BOX_SIZE),
        .STEP  (STEP)
    ) u_axis_x (
        .CLK     (CLK),
        .RST     (RST),
        .STEP_EN (frame_step),
        .POS     (x_pos),
        .DIR     (x_dir),
        .BOUNCE  (x_bounce)
    );

    box_axis #(
        .LIMIT (HEIGHT - BOX_SIZE),
        .STEP  (STEP)
    ) u_axis_y (
        .CLK     (CLK),
        .RST     (RST),
        .STEP_EN (frame_step),
        .POS     (y_pos),
        .DIR     (y_dir),
        .BOUNCE  (y_bounce)
    );

    // Directions live inside the axes; the generator only needs the bounce flags.
    assign unused_dir = x_dir ^ y_dir;

    // A corner hit reverses both axes in one frame but is a single event.
    assign bounce_evt = x_bounce | y_bounce;

    // Box test at 11 bits so position + BOX_SIZE cannot overflow.
    assign h_ext  = {1'b0, H_CNT};
    assign v_ext  = {1'b0, V_CNT};
    assign x_ext  = {1'b0, x_pos};
    assign y_ext  = {1'b0, y_pos};
    assign in_box = (h_ext >= x_ext) && (h_ext < x_ext + BOX_W) &&
                    (v_ext >= y_ext) && (v_ext < y_ext + BOX_W);

    // Pixel colour from the current (pre-update) position and palette, plus
    // next bounce count and palette index.
    always_comb begin
        rgb_d = RGB_BLACK;
        if (ACTIVE) begin
            rgb_d = in_box ? palette_colour(pal_q) : RGB_BACKGROUND;
        end
        cnt_d = cnt_q;
        pal_d = pal_q;
        if (bounce_evt) begin
            cnt_d = cnt_q + 8'd1;
            pal_d = pal_q + 2'd1;
        end
    end

    // Colour, counter and palette registers advance only on pixel enables.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rgb_q <= RGB_BLACK;
            cnt_q <= '0;
            pal_q <= '0;
        end else if (PIX_EN) begin
            rgb_q <= rgb_d;
            cnt_q <= cnt_d;
            pal_q <= pal_d;
        end
    end

    assign VGA_R      = rgb_q.r;
    assign VGA_G      = rgb_q.g;
    assign VGA_B      = rgb_q.b;
    assign BOUNCE_CNT = cnt_q;

endmodule

// File: tb/tb_bounce_box_gen.sv
// Self-checking bench for bounce_box_gen: a default 640x480 instance and a
// square 640x640 instance (where a true corner hit is reachable), both
// checked against a frame-level model of the box motion and colouring.
module tb_bounce_box_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pix_en = 1'b0;
    logic       active = 1'b0;
    logic       frame_start = 1'b0;
    logic [9:0] h_cnt = '0;
    logic [9:0] v_cnt = '0;

    logic [3:0] r0, g0, b0, r1, g1, b1;
    logic [7:0] cnt0, cnt1;

    always #10 clk = ~clk;

    bounce_box_gen u_main (
        .CLK         (clk),
        .RST         (rst),
        .PIX_EN      (pix_en),
        .H_CNT       (h_cnt),
        .V_CNT       (v_cnt),
        .ACTIVE      (active),
        .FRAME_START (frame_start),
        .VGA_R       (r0),
        .VGA_G       (g0),
        .VGA_B       (b0),
        .BOUNCE_CNT  (cnt0)
    );

    bounce_box_gen #(
        .BOX_SIZE (32),
        .STEP     (2),
        .WIDTH    (640),
        .HEIGHT   (640)
    ) u_sq (
        .CLK         (clk),
        .RST         (rst),
        .PIX_EN      (pix_en),
        .H_CNT       (h_cnt),
        .V_CNT       (v_cnt),
        .ACTIVE      (active),
        .FRAME_START (frame_start),
        .VGA_R       (r1),
        .VGA_G       (g1),
        .VGA_B       (b1),
        .BOUNCE_CNT  (cnt1)
    );

    // Frame-level model: signed position, wall limits, total bounce events.
    typedef struct {
        int          x;
        int          y;
        bit          dx;
        bit          dy;
        int          events;
        int          lim_x;
        int          lim_y;
        logic [11:0] rgb;
    } model_t;

    typedef struct {
        int          h;
        int          v;
        bit          act;
        logic [11:0] rgb;
    } vec_t;

    model_t m[2];
    vec_t   vecs[7];
    int     total = 0;
    int     bad = 0;

    task automatic check(input string name, input int actual, input int expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    function automatic logic [11:0] pal_colour(input int events);
        case (events % 4)
            0:       return 12'hF00;
            1:       return 12'h0F0;
            2:       return 12'h00F;
            default: return 12'hFF0;
        endcase
    endfunction

    function automatic logic [11:0] model_pixel(input int k, input int h, input int v, input bit act);
        if (!act) return 12'h000;
        if (h >= m[k].x && h < m[k].x + 32 && v >= m[k].y && v < m[k].y + 32)
            return pal_colour(m[k].events);
        return 12'h004;
    endfunction

    // Move one step in the current direction; landing on or past a wall parks
    // the box on that wall and turns it around.
    function automatic void step_axis(inout int p, inout bit d, input int lim, inout bit hit);
        int cand;
        cand = d ? p + 2 : p - 2;
        if (cand >= lim) begin
            p = lim; d = 1'b0; hit = 1'b1;
        end else if (cand <= 0) begin
            p = 0; d = 1'b1; hit = 1'b1;
        end else begin
            p = cand;
        end
    endfunction

    function automatic void model_frame(input int k);
        int p;
        bit d;
        bit hit;
        hit = 1'b0;
        p = m[k].x; d = m[k].dx;
        step_axis(p, d, m[k].lim_x, hit);
        m[k].x = p; m[k].dx = d;
        p = m[k].y; d = m[k].dy;
        step_axis(p, d, m[k].lim_y, hit);
        m[k].y = p; m[k].dy = d;
        if (hit) m[k].events++;
    endfunction

    function automatic void model_reset(input int k);
        m[k].x = 0; m[k].y = 0; m[k].dx = 1'b1; m[k].dy = 1'b1;
        m[k].events = 0; m[k].rgb = 12'h000;
    endfunction

    // One clock: drive at the falling edge, update the model at the rising
    // edge, return 1 ns later so outputs are settled for sampling.
    task automatic cycle(input bit en, input bit fs, input int h, input int v, input bit act, input bit r);
        @(negedge clk);
        pix_en = en; frame_start = fs; h_cnt = 10'(h); v_cnt = 10'(v); active = act; rst = r;
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (r) begin
                model_reset(k);
            end else if (en) begin
                m[k].rgb = model_pixel(k, h, v, act);
                if (fs) model_frame(k);
            end
        end
        #1;
    endtask

    task automatic pix(input bit fs, input int h, input int v, input bit act);
        cycle(1'b1, fs, h, v, act, 1'b0);
        cycle(1'b0, 1'b0, h, v, act, 1'b0);
    endtask

    task automatic frame();
        pix(1'b1, 0, 0, 1'b1);
    endtask

    task automatic probe0(input string name, input int h, input int v, input bit act, input logic [11:0] exp);
        pix(1'b0, h, v, act);
        check(name, {r0, g0, b0}, exp);
    endtask

    task automatic probe1(input string name, input int h, input int v, input bit act, input logic [11:0] exp);
        pix(1'b0, h, v, act);
        check(name, {r1, g1, b1}, exp);
    endtask

    task automatic check_model(input string tag);
        check({tag, ".rgb0"}, {r0, g0, b0}, m[0].rgb);
        check({tag, ".cnt0"}, cnt0, m[0].events % 256);
        check({tag, ".rgb1"}, {r1, g1, b1}, m[1].rgb);
        check({tag, ".cnt1"}, cnt1, m[1].events % 256);
    endtask

    initial begin
        int guard;
        int last;
        int h;
        int v;

        m[0].lim_x = 608; m[0].lim_y = 448;
        m[1].lim_x = 608; m[1].lim_y = 608;
        model_reset(0);
        model_reset(1);

        // Pixel table around the box at (100,100), palette 0.
        vecs[0] = '{100, 100, 1'b1, 12'hF00};
        vecs[1] = '{132, 100, 1'b1, 12'h004};
        vecs[2] = '{131, 131, 1'b1, 12'hF00};
        vecs[3] = '{ 99, 100, 1'b1, 12'h004};
        vecs[4] = '{100, 132, 1'b1, 12'h004};
        vecs[5] = '{100, 100, 1'b0, 12'h000};
        vecs[6] = '{131,  99, 1'b1, 12'h004};

        // Reset for three clocks, pixel enable toggling underneath.
        for (int i = 0; i < 3; i++) cycle(1'(i % 2), 1'b0, 0, 0, 1'b0, 1'b1);
        check("reset_rgb", {r0, g0, b0}, 12'h000);
        check("reset_cnt", cnt0, 0);
        check("reset_cnt_sq", cnt1, 0);
        cycle(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);

        // First frame renders the box at 0..31.
        probe0("first_tl", 0, 0, 1'b1, 12'hF00);
        probe0("first_br", 31, 31, 1'b1, 12'hF00);
        probe0("first_right", 32, 0, 1'b1, 12'h004);
        probe0("first_below", 0, 32, 1'b1, 12'h004);
        probe0("first_blank", 5, 5, 1'b0, 12'h000);

        // The FRAME_START pixel sees the old position; the step shows next.
        pix(1'b1, 0, 0, 1'b1);
        check("fs_pixel_old_pos", {r0, g0, b0}, 12'hF00);
        probe0("after_step_out", 1, 1, 1'b1, 12'h004);
        probe0("after_step_in", 2, 2, 1'b1, 12'hF00);

        // Frame 50: box at (100,100).
        repeat (49) frame();
        for (int i = 0; i < 7; i++) begin
            pix(1'b0, vecs[i].h, vecs[i].v, vecs[i].act);
            check($sformatf("vec%0d", i), {r0, g0, b0}, vecs[i].rgb);
        end

        // Frame 303: main at (606,290) after one floor bounce; square at (606,606).
        repeat (253) frame();
        check("pre_wall_cnt", cnt0, 1);
        probe0("pre_wall_in", 606, 290, 1'b1, 12'h0F0);
        probe0("pre_wall_out", 605, 290, 1'b1, 12'h004);
        check("pre_corner_cnt", cnt1, 0);
        probe1("pre_corner_in", 606, 606, 1'b1, 12'hF00);

        // Frame 304: right-wall hit on main, corner hit on the square instance.
        frame();
        check("wall_cnt", cnt0, 2);
        probe0("wall_in", 608, 288, 1'b1, 12'h00F);
        probe0("wall_far", 639, 319, 1'b1, 12'h00F);
        probe0("wall_out", 607, 288, 1'b1, 12'h004);
        check("corner_cnt", cnt1, 1);
        probe1("corner_in", 608, 608, 1'b1, 12'h0F0);
        probe1("corner_far", 639, 639, 1'b1, 12'h0F0);
        probe1("corner_out", 608, 607, 1'b1, 12'h004);

        // Frame 305: both boxes head back.
        frame();
        probe0("rebound_in", 606, 286, 1'b1, 12'h00F);
        probe0("rebound_out", 638, 286, 1'b1, 12'h004);
        check("rebound_cnt", cnt0, 2);
        check("corner_once", cnt1, 1);
        probe1("corner_back_in", 606, 606, 1'b1, 12'h0F0);
        probe1("corner_back_out", 638, 606, 1'b1, 12'h004);

        // FRAME_START without PIX_EN: nothing moves, outputs hold.
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b1, 40 * i, 20 * i, 1'b1, 1'b0);
            check_model($sformatf("gate%0d", i));
        end
        probe0("gate_pos_in", 606, 286, 1'b1, 12'h00F);
        probe0("gate_pos_out", 605, 286, 1'b1, 12'h004);

        // Reset pulse with PIX_EN low still applies.
        cycle(1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
        check("gated_rst_rgb", {r0, g0, b0}, 12'h000);
        check("gated_rst_cnt", cnt0, 0);
        check("gated_rst_cnt_sq", cnt1, 0);
        cycle(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
        probe0("post_rst_in", 0, 0, 1'b1, 12'hF00);
        probe0("post_rst_out", 32, 32, 1'b1, 12'h004);

        // 256 bounce events from reset: counter and palette both wrap.
        guard = 0;
        last = 0;
        while (m[0].events < 256 && guard < 40000) begin
            cycle(1'b1, 1'b1, 0, 0, 1'b1, 1'b0);
            guard++;
            if (m[0].events != last) begin
                last = m[0].events;
                check($sformatf("wrap_cnt%0d", last), cnt0, last % 256);
            end
        end
        if (guard >= 40000) check("wrap_budget", m[0].events, 256);
        check("wrap_zero", cnt0, 0);
        probe0("wrap_palette", m[0].x, m[0].y, 1'b1, 12'hF00);

        // Random enables, frame starts, resets and coordinates near the box.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                h = m[0].x + int'($urandom_range(0, 40)) - 4;
                v = m[0].y + int'($urandom_range(0, 40)) - 4;
            end else begin
                h = int'($urandom_range(0, 639));
                v = int'($urandom_range(0, 479));
            end
            if (h < 0) h = 0;
            if (h > 639) h = 639;
            if (v < 0) v = 0;
            if (v > 479) v = 479;
            cycle(1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0, h, v,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0);
            check_model($sformatf("rand%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
